bram_wr_port_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 3-to-1 BRAM write-port multiplexer in the transpose-convolution accumulation path.
- Requesters: 0 = Accumulation Unit, 1 = Bias Load (AXI), 2 = Standard Convolution.
- Drives the mux select and a write-enable gate. Guarantees one dead cycle on every ownership change, so no BRAM write happens while the select is moving.
- Bounds each ownership burst so that no requester can starve the others.

---
 rtl/bram_wr_port_arbiter_if.sv | 11 +
 rtl/bram_wr_port_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/bram_wr_port_arbiter_if.sv
// bram_wr_port_arbiter_if: request/grant bundle between BRAM write requesters and the write-port arbiter.
interface bram_wr_port_arbiter_if;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       wr_en_gate;
    logic       owner_valid;
    logic       preempt;
    modport master (output req, input gnt, sel, wr_en_gate, owner_valid, preempt);
    modport slave  (input req, output gnt, sel, wr_en_gate, owner_valid, preempt);
endinterface

// File: rtl/bram_wr_port_arbiter.sv
// bram_wr_port_arbiter: round-robin owner sequencer for the 3-to-1 BRAM write-port mux,
// inserting one dead cycle on every handover and bounding each ownership burst.
module bram_wr_port_arbiter #(
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 9
) (
    input logic clk,
    input logic rst_n,
    bram_wr_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWITCH, OWN} state_t;
    state_t state, state_nx;
    logic [1:0] sel_q, sel_nx, last, last_nx, c1, c2, win;
    logic [2:0] gnt_q, gnt_nx, own_mask, pending;
    logic pre_q, pre_nx, found;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;
    // While owning, the owner is excluded so a release or preempt hands over to someone else.
    always_comb begin
        own_mask = (state == OWN) ? (3'b001 << sel_q) : 3'b000;
        pending  = bus.req & ~own_mask;
        c1       = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2       = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        win      = pending[c1] ? c1 : pending[c2] ? c2 : last;
        found    = |pending;
    end
    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        last_nx  = last;
        gnt_nx   = 3'b000;
        pre_nx   = 1'b0;
        cnt_nx   = burst_cnt;
        unique case (state)
            IDLE: begin
                state_nx = found ? SWITCH : IDLE;
                sel_nx   = found ? win : sel_q;
            end
            SWITCH: begin
                state_nx = bus.req[sel_q] ? OWN : IDLE;
                gnt_nx   = bus.req[sel_q] ? (3'b001 << sel_q) : 3'b000;
                cnt_nx   = bus.req[sel_q] ? CNT_W'(1) : burst_cnt;
                last_nx  = bus.req[sel_q] ? sel_q : last;
            end
            OWN: begin
                if (!bus.req[sel_q]) begin
                    state_nx = found ? SWITCH : IDLE;
                    sel_nx   = found ? win : sel_q;
                    cnt_nx   = '0;
                end else if (burst_cnt == CNT_W'(MAX_BURST) && found) begin
                    state_nx = SWITCH;
                    sel_nx   = win;
                    pre_nx   = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    gnt_nx = gnt_q;
                    cnt_nx = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= 2'd0;
            last      <= 2'd2;
            gnt_q     <= 3'b000;
            pre_q     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            sel_q     <= sel_nx;
            last      <= last_nx;
            gnt_q     <= gnt_nx;
            pre_q     <= pre_nx;
            burst_cnt <= cnt_nx;
        end
    end
    assign bus.gnt         = gnt_q;
    assign bus.sel         = sel_q;
    assign bus.wr_en_gate  = |gnt_q;
    assign bus.owner_valid = (state == OWN);
    assign bus.preempt     = pre_q;
endmodule
